// File: rtl/shared_sqscmul_pipe.sv
// Masked GF(2^4) multiply / square-scale-multiply, valid/ready pipelined.
// Stage 1 registers every cross-share product X_k*Y_l, already refreshed with
// Z or with the diagonal sqsc/blinding term, before any cross-domain XOR.
// Stage 2 compresses each domain row and optionally registers the result.
// The whole pipe advances in lockstep, so a stall freezes every register.
module shared_sqscmul_pipe #(
    parameter int SHARES   = 4,
    parameter int OUT_REG  = 1,
    parameter int BLIND    = 1,
    parameter int SWAP_OUT = 1,
    parameter int CNT_W    = 8
) (
    input  logic                            ClkxCI,
    input  logic                            RstxRI,
    input  logic                            InValidxSI,
    output logic                            InReadyxSO,
    input  logic                            ModexSI,
    input  logic [4*SHARES-1:0]             XxDI,
    input  logic [4*SHARES-1:0]             YxDI,
    input  logic [2*SHARES*(SHARES-1)-1:0]  ZxDI,
    input  logic [4*SHARES-1:0]             BxDI,
    output logic                            OutValidxSO,
    input  logic                            OutReadyxSI,
    output logic [4*SHARES-1:0]             QxDO,
    output logic [CNT_W-1:0]                TxnCntxDO
);

    // Scaling constant applied after squaring in the square-scaler.
    localparam logic [3:0] SQSC_LAMBDA = 4'hC;

    // GF(2^4) multiply, polynomial basis, modulus x^4 + x + 1.
    function automatic logic [3:0] gf2_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ ({3'b000, a} << i);
        end
        for (int j = 6; j >= 4; j--) begin
            if (p[j]) p = p ^ (7'b0010011 << (j - 4));
        end
        return p[3:0];
    endfunction

    // Squaring is GF(2)-linear: x^4 -> x+1, x^6 -> x^3+x^2.
    function automatic logic [3:0] gf2_sq(input logic [3:0] a);
        return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
    endfunction

    function automatic logic [3:0] square_scaler(input logic [3:0] a);
        return gf2_mul(gf2_sq(a), SQSC_LAMBDA);
    endfunction

    logic                                 adv;
    logic                                 last_valid;
    logic                                 out_hs;
    logic                                 v1_q, v1_d;
    logic [SHARES-1:0][SHARES-1:0][3:0]   ff_q, ff_d;
    logic [SHARES-1:0][3:0]               q_comb;
    logic [SHARES-1:0][3:0]               q_res;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;

    assign adv         = ~last_valid | OutReadyxSI;
    assign InReadyxSO  = adv;
    assign OutValidxSO = last_valid;
    assign out_hs      = last_valid & OutReadyxSI;
    assign TxnCntxDO   = cnt_q;

    // Stage-1 next state: all share products plus their refresh term, taken only on accept.
    always_comb begin
        logic [3:0] r;
        int         idx;
        ff_d = ff_q;
        v1_d = adv ? InValidxSI : v1_q;
        r    = '0;
        idx  = 0;
        if (adv && InValidxSI) begin
            for (int k = 0; k < SHARES; k++) begin
                for (int l = 0; l < SHARES; l++) begin
                    if (k == l) begin
                        r = ModexSI ? square_scaler(XxDI[4*k +: 4] ^ YxDI[4*k +: 4]) : 4'h0;
                        if (BLIND != 0) r = r ^ BxDI[4*k +: 4];
                    end else begin
                        // Both halves of a pair share one mask so it cancels on recombination.
                        idx = (k < l) ? (k + l*(l-1)/2) : (l + k*(k-1)/2);
                        r   = ZxDI[4*idx +: 4];
                    end
                    ff_d[k][l] = gf2_mul(XxDI[4*k +: 4], YxDI[4*l +: 4]) ^ r;
                end
            end
        end
    end

    // Stage-1 registers.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            v1_q <= 1'b0;
            ff_q <= '0;
        end else begin
            v1_q <= v1_d;
            ff_q <= ff_d;
        end
    end

    // Per-domain compression of the registered row.
    always_comb begin
        q_comb = '0;
        for (int k = 0; k < SHARES; k++) begin
            for (int l = 0; l < SHARES; l++) begin
                q_comb[k] = q_comb[k] ^ ff_q[k][l];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                   v2_q, v2_d;
            logic [SHARES-1:0][3:0] qr_q, qr_d;

            // Output stage loads whenever the pipe moves; an empty stage 1 leaves a bubble.
            always_comb begin
                v2_d = adv ? v1_q : v2_q;
                qr_d = (adv && v1_q) ? q_comb : qr_q;
            end

            // Output stage registers.
            always_ff @(posedge ClkxCI) begin
                if (RstxRI) begin
                    v2_q <= 1'b0;
                    qr_q <= '0;
                end else begin
                    v2_q <= v2_d;
                    qr_q <= qr_d;
                end
            end

            assign last_valid = v2_q;
            assign q_res      = qr_q;
        end else begin : g_out_comb
            assign last_valid = v1_q;
            assign q_res      = q_comb;
        end
    endgenerate

    // Output nibble ordering.
    always_comb begin
        QxDO = '0;
        for (int k = 0; k < SHARES; k++) begin
            QxDO[4*k +: 4] = (SWAP_OUT != 0) ? {q_res[k][1:0], q_res[k][3:2]} : q_res[k];
        end
    end

    // Completed-handshake counter, wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (out_hs) cnt_d = cnt_q + CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: tb/tb_shared_sqscmul_pipe.sv
// Bench: main DUT (OUT_REG=1, SWAP_OUT=1, BLIND=1, CNT_W=8) checked against a
// scoreboard of recombined results; a second DUT (OUT_REG=0, no swap, no
// blinding, CNT_W=2, always ready) sees the same inputs for latency-1/wrap checks.
module tb_shared_sqscmul_pipe;
    localparam int S = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, out_ready, mode;
    logic [4*S-1:0]  x, y, b;
    logic [2*S*(S-1)-1:0] z;
    logic            in_ready, out_valid;
    logic [4*S-1:0]  q;
    logic [7:0]      cnt;
    logic            in_ready2, out_valid2;
    logic [4*S-1:0]  q2;
    logic [1:0]      cnt2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shared_sqscmul_pipe #(.SHARES(S), .OUT_REG(1), .BLIND(1), .SWAP_OUT(1), .CNT_W(8)) u_dut (
        .ClkxCI(clk), .RstxRI(rst), .InValidxSI(in_valid), .InReadyxSO(in_ready),
        .ModexSI(mode), .XxDI(x), .YxDI(y), .ZxDI(z), .BxDI(b),
        .OutValidxSO(out_valid), .OutReadyxSI(out_ready), .QxDO(q), .TxnCntxDO(cnt));

    shared_sqscmul_pipe #(.SHARES(S), .OUT_REG(0), .BLIND(0), .SWAP_OUT(0), .CNT_W(2)) u_dut2 (
        .ClkxCI(clk), .RstxRI(rst), .InValidxSI(in_valid), .InReadyxSO(in_ready2),
        .ModexSI(mode), .XxDI(x), .YxDI(y), .ZxDI(z), .BxDI(b),
        .OutValidxSO(out_valid2), .OutReadyxSI(1'b1), .QxDO(q2), .TxnCntxDO(cnt2));

    // Reference field arithmetic: shift-and-add with xtime.
    function automatic logic [3:0] m_mul(input logic [3:0] a, input logic [3:0] bb);
        logic [3:0] acc, aa;
        acc = 4'h0; aa = a;
        for (int i = 0; i < 4; i++) begin
            if (bb[i]) acc = acc ^ aa;
            aa = aa[3] ? ((aa << 1) ^ 4'h3) : (aa << 1);
        end
        return acc;
    endfunction

    function automatic logic [3:0] m_sqsc(input logic [3:0] a);
        return m_mul(m_mul(a, a), 4'hC);
    endfunction

    function automatic logic [3:0] recomb(input logic [4*S-1:0] v);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 0; i < S; i++) r = r ^ v[4*i +: 4];
        return r;
    endfunction

    function automatic logic [3:0] swp(input logic [3:0] v);
        return {v[1:0], v[3:2]};
    endfunction

    function automatic logic [3:0] model(input logic m, input logic [4*S-1:0] xs, input logic [4*S-1:0] ys);
        logic [3:0] xv, yv;
        xv = recomb(xs); yv = recomb(ys);
        return m_mul(xv, yv) ^ (m ? m_sqsc(xv ^ yv) : 4'h0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Share a value randomly, pick fresh Z and (optionally) zero-sum blinding.
    task automatic load(input logic m, input logic [3:0] xv, input logic [3:0] yv, input bit zero_b);
        logic [3:0] ax, ay, ab;
        ax = xv; ay = yv; ab = 4'h0;
        for (int i = 0; i < S-1; i++) begin
            x[4*i +: 4] = 4'($urandom_range(0, 15)); ax = ax ^ x[4*i +: 4];
            y[4*i +: 4] = 4'($urandom_range(0, 15)); ay = ay ^ y[4*i +: 4];
            b[4*i +: 4] = zero_b ? 4'h0 : 4'($urandom_range(0, 15)); ab = ab ^ b[4*i +: 4];
        end
        x[4*(S-1) +: 4] = ax;
        y[4*(S-1) +: 4] = ay;
        b[4*(S-1) +: 4] = ab;
        z = $urandom();
        mode = m;
    endtask

    // Present one transaction and hold it until accepted (bounded).
    task automatic send(input logic m, input logic [3:0] xv, input logic [3:0] yv, input bit zero_b);
        bit acc;
        acc = 1'b0;
        load(m, xv, yv, zero_b);
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard and per-cycle protocol checks.
    logic [3:0] sb[$];
    logic [7:0] cnt_m;
    logic [1:0] cnt2_m;
    logic       stall_prev, prev2_v;
    logic [4*S-1:0] q_prev;
    logic [3:0] prev2_exp;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            cnt_m = 8'd0; cnt2_m = 2'd0;
            stall_prev = 1'b0; prev2_v = 1'b0;
        end else begin
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            chk("txn_cnt", cnt, cnt_m);
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_q_stable", q, q_prev);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("spurious_out", 32'd1, 32'd0);
                else chk("result", recomb(q), sb.pop_front());
                cnt_m = cnt_m + 8'd1;
            end
            if (in_valid && in_ready) sb.push_back(swp(model(mode, x, y)));
            stall_prev = out_valid && !out_ready;
            q_prev = q;
            chk("lat1_valid", out_valid2, prev2_v);
            if (prev2_v) chk("lat1_result", recomb(q2), prev2_exp);
            chk("lat1_cnt", cnt2, cnt2_m);
            if (out_valid2) cnt2_m = cnt2_m + 2'd1;
            prev2_v = in_valid;
            prev2_exp = model(mode, x, y);
        end
    end

    initial begin
        int c0;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; mode = 1'b0;
        x = '0; y = '0; z = '0; b = '0;

        // Model pinned with hand-computed field values.
        chk("model_mul_1x6", m_mul(4'h1, 4'h6), 4'h6);
        chk("model_mul_2x8", m_mul(4'h2, 4'h8), 4'h3);
        chk("model_mul_3x7", m_mul(4'h3, 4'h7), 4'h9);
        chk("model_sqsc_1", m_sqsc(4'h1), 4'hC);
        chk("model_sqsc_0", m_sqsc(4'h0), 4'h0);

        // T1 reset with input valid asserted.
        step(2);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_q", q, 16'h0);
        chk("rst_cnt", cnt, 8'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // T2 latency 2, 1*6 swapped.
        send(1'b0, 4'h1, 4'h6, 1'b1);
        @(negedge clk);
        chk("t2_not_yet", out_valid, 1'b0);
        @(negedge clk);
        chk("t2_valid", out_valid, 1'b1);
        chk("t2_q", recomb(q), 4'h9);
        @(posedge clk); #1;

        // T3 mode 1 with blinding.
        send(1'b1, 4'h1, 4'h1, 1'b0);
        @(negedge clk); @(negedge clk);
        chk("t3_valid", out_valid, 1'b1);
        chk("t3_q", recomb(q), 4'h4);
        @(posedge clk); #1;

        // T4 16 back-to-back after a clean reset.
        rst = 1'b1; step(1); rst = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 16; i++)
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
        chk("t4_throughput", cyc - c0, 16);
        step(3);
        @(negedge clk);
        chk("t4_cnt", cnt, 8'd16);
        @(posedge clk); #1;

        // T5 stall with two results held.
        out_ready = 1'b0;
        send(1'b1, 4'hA, 4'h3, 1'b0);
        send(1'b0, 4'h7, 4'hE, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_in_ready_low", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        step(4);
        @(negedge clk);
        chk("t5_cnt", cnt, 8'd18);
        chk("t5_drained", out_valid, 1'b0);
        @(posedge clk); #1;

        // T6 reset with two in flight, then counter wrap on the 2-bit instance.
        send(1'b0, 4'h5, 4'h9, 1'b0);
        send(1'b1, 4'h2, 4'hB, 1'b0);
        rst = 1'b1; step(1); rst = 1'b0;
        @(negedge clk);
        chk("t6_flushed", out_valid, 1'b0);
        chk("t6_cnt_clr", cnt, 8'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++)
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
        step(3);
        @(negedge clk);
        chk("t6_cnt", cnt, 8'd5);
        chk("t6_cnt_wrap", cnt2, 2'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
